// File: rtl/cu_micro_sequencer.sv
// Microprogram sequencer: owns the CAR, addresses synchronous control memory, issues microwords.
// Optional micro-step counter is enabled by defining CU_USTEP_COUNT_EN.
module cu_micro_sequencer #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic [7:0]        opcode,
    input  logic              flag_z,
    input  logic              flag_n,
    output logic [ADDR_W-1:0] ctrl_mem_addr,
    input  logic [WORD_W-1:0] ctrl_mem_data,
    output logic [WORD_W-1:0] cbr_word,
`ifdef CU_USTEP_COUNT_EN
    output logic [15:0]       ustep_count,
`endif
    output logic              busy,
    output logic              halted
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [3:0] SEQ_INC      = 4'd0;
    localparam logic [3:0] SEQ_FETCH    = 4'd1;
    localparam logic [3:0] SEQ_DISPATCH = 4'd2;
    localparam logic [3:0] SEQ_SKIPZ    = 4'd3;
    localparam logic [3:0] SEQ_SKIPN    = 4'd4;
    localparam logic [3:0] SEQ_HALT     = 4'd5;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

    logic [1:0]        state;
    logic [ADDR_W-1:0] car;
    logic [ADDR_W-1:0] next_addr;
    logic [3:0]        seq;
    logic              issue;
    logic              go_halt;

    assign seq   = ctrl_mem_data[19:16];
    assign issue = (state == S_RUN) && !stall;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        next_addr = car;
        go_halt   = 1'b0;
        if (state == S_IDLE) begin
            next_addr = '0;
        end else if (issue) begin
            case (seq)
                SEQ_INC:      next_addr = car + ONE;
                SEQ_FETCH:    next_addr = '0;
                SEQ_DISPATCH: next_addr = {opcode[ADDR_W-3:0], 2'b00};
                SEQ_SKIPZ:    next_addr = flag_z ? car + TWO : car + ONE;
                SEQ_SKIPN:    next_addr = flag_n ? car + TWO : car + ONE;
                SEQ_HALT:     go_halt   = 1'b1;
                default:      next_addr = '0;
            endcase
        end
    end

    assign ctrl_mem_addr = next_addr;
    assign cbr_word      = issue ? ctrl_mem_data : '0;
    assign busy          = (state == S_RUN);
    assign halted        = (state == S_HALT);

    // NOTE: state uses non-blocking assignments; reset is asynchronous so outputs drop instantly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            car   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_RUN;
                S_RUN: begin
                    car <= next_addr;
                    if (go_halt) state <= S_HALT;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CU_USTEP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ustep_count <= '0;
        end else if (state == S_IDLE && start) begin
            ustep_count <= '0;
        end else if (issue && ustep_count != 16'hFFFF) begin
            ustep_count <= ustep_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cu_micro_sequencer.sv
// Self-checking bench for cu_micro_sequencer: behavioural model plus directed literal checks.
// Counter checks are compiled in when CU_USTEP_COUNT_EN is defined.
module tb_cu_micro_sequencer;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stall, flag_z, flag_n;
    logic [7:0]    opcode;
    logic [AW-1:0] ctrl_mem_addr;
    logic [23:0]   ctrl_mem_data;
    logic [23:0]   cbr_word;
    logic          busy, halted;
`ifdef CU_USTEP_COUNT_EN
    logic [15:0]   ustep_count;
`endif

    logic [23:0] rom [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    cu_micro_sequencer #(.ADDR_W(AW), .WORD_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .opcode(opcode),
        .flag_z(flag_z), .flag_n(flag_n), .ctrl_mem_addr(ctrl_mem_addr),
        .ctrl_mem_data(ctrl_mem_data), .cbr_word(cbr_word),
`ifdef CU_USTEP_COUNT_EN
        .ustep_count(ustep_count),
`endif
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ctrl_mem_data <= rom[ctrl_mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a running flag, a halted flag and a program counter over the ROM.
    logic m_run, m_halt;
    int   m_car;
    int   m_count;

    function automatic int m_next(input int car);
        logic [23:0] w;
        w = rom[car];
        case (int'(w[19:16]))
            0:       return (car + 1) % DEPTH;
            2:       return int'(opcode[5:0]) * 4;
            3:       return flag_z ? (car + 2) % DEPTH : (car + 1) % DEPTH;
            4:       return flag_n ? (car + 2) % DEPTH : (car + 1) % DEPTH;
            5:       return car;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_halt <= 1'b0; m_car <= 0; m_count <= 0;
        end else if (!m_run && !m_halt) begin
            if (start) begin
                m_run <= 1'b1;
                m_count <= 0;
            end
        end else if (m_run && !stall) begin
            if (m_count < 65535) m_count <= m_count + 1;
            if (rom[m_car][19:16] == 4'd5) begin
                m_run  <= 1'b0;
                m_halt <= 1'b1;
            end
            m_car <= m_next(m_car);
        end
    end

    always @(negedge clk) begin
        int exp_addr;
        logic [23:0] exp_word;
        exp_addr = (m_run && !stall) ? m_next(m_car) : m_car;
        exp_word = (m_run && !stall) ? rom[m_car] : 24'h0;
        check("cyc_addr", 32'(ctrl_mem_addr), 32'(exp_addr));
        check("cyc_cbr", 32'(cbr_word), 32'(exp_word));
        check("cyc_busy", 32'(busy), 32'(m_run));
        check("cyc_halted", 32'(halted), 32'(m_halt));
`ifdef CU_USTEP_COUNT_EN
        check("cyc_count", 32'(ustep_count), 32'(m_count));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = 24'h0;
    endtask

    // Reset, then pulse start; returns in the first RUN cycle (CAR=0).
    task automatic restart();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; opcode = 8'h00;
        flag_z = 1'b0; flag_n = 1'b0;
        clear_rom();
        #12;
        check("rst_cbr", 32'(cbr_word), 32'h0);
        check("rst_addr", 32'(ctrl_mem_addr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);

        // INC / FETCH loop
        rom[0] = 24'h000001;
        rom[1] = 24'h010002;
        restart();
        check("start_cbr0", 32'(cbr_word), 32'h000001);
        check("start_addr0", 32'(ctrl_mem_addr), 32'h1);
        check("start_busy", 32'(busy), 32'h1);
        tick(); #1;
        check("fetch_cbr1", 32'(cbr_word), 32'h010002);
        check("fetch_addr1", 32'(ctrl_mem_addr), 32'h0);
        tick(); #1;
        check("loop_cbr2", 32'(cbr_word), 32'h000001);
        check("loop_addr2", 32'(ctrl_mem_addr), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_cbr", 32'(cbr_word), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_addr", 32'(ctrl_mem_addr), 32'h0);

        // DISPATCH
        clear_rom();
        rom[0]  = 24'h020000;
        rom[20] = 24'h000ABC;
        opcode  = 8'h05;
        restart();
        check("dispatch_addr", 32'(ctrl_mem_addr), 32'h14);
        tick(); #1;
        check("dispatch_cbr", 32'(cbr_word), 32'h000ABC);
        check("dispatch_next", 32'(ctrl_mem_addr), 32'h15);

        // SKIPZ at CAR=7
        clear_rom();
        rom[7] = 24'h030007;
        rom[9] = 24'h000909;
        restart();
        repeat (7) tick();
        flag_z = 1'b1; #1;
        check("skipz_taken", 32'(ctrl_mem_addr), 32'h9);
        flag_z = 1'b0; #1;
        check("skipz_not_taken", 32'(ctrl_mem_addr), 32'h8);
        flag_z = 1'b1;
        tick(); #1;
        check("skipz_cbr", 32'(cbr_word), 32'h000909);
        flag_z = 1'b0;

        // SKIPN near the top of memory and INC wrap
        clear_rom();
        rom[0]    = 24'h020000;
        rom[8'hFE] = 24'h040000;
        opcode    = 8'h3F;
        restart();
        check("dispatch_fc", 32'(ctrl_mem_addr), 32'hFC);
        repeat (3) tick();
        flag_n = 1'b0; #1;
        check("skipn_fe_not_taken", 32'(ctrl_mem_addr), 32'hFF);
        tick(); #1;
        check("inc_wrap", 32'(ctrl_mem_addr), 32'h0);
        repeat (4) tick();
        flag_n = 1'b1; #1;
        check("skipn_fe_wrap", 32'(ctrl_mem_addr), 32'h0);
        tick(); #1;
        check("skipn_wrap_cbr", 32'(cbr_word), 32'h020000);
        flag_n = 1'b0;

        // Stall at CAR=4, then a stalled HALT word
        clear_rom();
        rom[4] = 24'h00AA55;
        rom[5] = 24'h050000;
        restart();
        repeat (4) tick();
        stall = 1'b1; #1;
        check("stall_cbr_0", 32'(cbr_word), 32'h0);
        check("stall_addr_0", 32'(ctrl_mem_addr), 32'h4);
        for (int i = 1; i < 3; i++) begin
            tick(); #1;
            check($sformatf("stall_cbr_%0d", i), 32'(cbr_word), 32'h0);
            check($sformatf("stall_addr_%0d", i), 32'(ctrl_mem_addr), 32'h4);
        end
        tick();
        stall = 1'b0; #1;
        check("stall_release_cbr", 32'(cbr_word), 32'h00AA55);
        check("stall_release_addr", 32'(ctrl_mem_addr), 32'h5);
        tick();
        stall = 1'b1; #1;
        check("halt_stalled_cbr", 32'(cbr_word), 32'h0);
        check("halt_stalled_busy", 32'(busy), 32'h1);
        tick();
        stall = 1'b0; #1;
        check("halt_word", 32'(cbr_word), 32'h050000);
        check("halt_word_addr", 32'(ctrl_mem_addr), 32'h5);
        tick(); #1;
        check("halted", 32'(halted), 32'h1);
        check("halted_busy", 32'(busy), 32'h0);
        check("halted_cbr", 32'(cbr_word), 32'h0);
`ifdef CU_USTEP_COUNT_EN
        check("count_held", 32'(ustep_count), 32'd6);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); #1;
        check("halt_sticky", 32'(halted), 32'h1);
        check("halt_start_ignored", 32'(busy), 32'h0);
        rst_n = 1'b0; #1;
        check("halt_rst_halted", 32'(halted), 32'h0);
        check("halt_rst_addr", 32'(ctrl_mem_addr), 32'h0);
        check("halt_rst_cbr", 32'(cbr_word), 32'h0);
`ifdef CU_USTEP_COUNT_EN
        check("count_rst", 32'(ustep_count), 32'd0);
        restart();
        check("count_start", 32'(ustep_count), 32'd0);
        tick(); #1;
        check("count_first", 32'(ustep_count), 32'd1);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
